// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding / hazard unit: operand source selects
// and the hard-wired zero register.
package fwd_pkg;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_scoreboard.sv
// Per-register countdown of pending long-latency writes; a register is busy
// while its counter is nonzero.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue,
    input  logic [REG_AW-1:0]      issue_rd,
    input  logic [LAT_W-1:0]       issue_lat,
    output logic [2**REG_AW-1:0]   busy
);

    localparam int NUM_REGS = 2**REG_AW;

    logic [LAT_W-1:0] cnt [NUM_REGS];

    // A fresh issue replaces whatever was pending on that register (WAW: latest wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (issue && r != REG_ZERO && issue_rd == REG_AW'(r)) begin
                    cnt[r] <= issue_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (r != REG_ZERO) && (cnt[r] != '0);
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, ID-stage stall on pending long-latency writes,
// and a saturating stall-cycle counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int LAT_W   = 3,
    parameter int PERF_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic [LAT_W-1:0]          id_lat,
    input  logic                      flush,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0]         ex_mem_rd,
    input  logic                      ex_mem_reg_write_en,
    input  logic [REG_AW-1:0]         mem_wb_rd,
    input  logic                      mem_wb_reg_write_en,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall_id,
    output logic [2**REG_AW-1:0]      sb_busy,
    output logic [PERF_W-1:0]         stall_cnt
);

    logic issue;
    logic dep_hit;

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_mem_reg_write_en && ex_mem_rd != REG_AW'(REG_ZERO) &&
                ex_mem_rd == ex_rs[i*REG_AW +: REG_AW]) begin
                fwd_sel[i*2 +: 2] = FWD_EXMEM;
            end else if (mem_wb_reg_write_en && mem_wb_rd != REG_AW'(REG_ZERO) &&
                         mem_wb_rd == ex_rs[i*REG_AW +: REG_AW]) begin
                fwd_sel[i*2 +: 2] = FWD_MEMWB;
            end else begin
                fwd_sel[i*2 +: 2] = FWD_NONE;
            end
        end
    end

    always_comb begin
        dep_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && sb_busy[id_rs[i*REG_AW +: REG_AW]]) begin
                dep_hit = 1'b1;
            end
        end
    end

    // stall_id comes only from registered busy state, so gating issue with it is loop-free.
    assign stall_id = id_valid & dep_hit;
    assign issue    = id_valid & ~stall_id & ~flush & (id_lat != '0) &
                      (id_rd != REG_AW'(REG_ZERO));

    fwd_scoreboard #(
        .REG_AW (REG_AW),
        .LAT_W  (LAT_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .issue_rd  (id_rd),
        .issue_lat (id_lat),
        .busy      (sb_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_id && stall_cnt != {PERF_W{1'b1}}) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule
